// File: rtl/lfsr_prbs_checker_if.sv
// Stream and status bundle between a PRBS bit source and lfsr_prbs_checker.
// The master drives the received stream and controls; the slave (checker) returns lock and error status.
interface lfsr_prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             i_en;
  logic             i_valid;
  logic             i_bit;
  logic             i_clear;
  logic             o_locked;
  logic             o_err;
  logic [CNT_W-1:0] o_err_cnt;
  logic [CNT_W-1:0] o_bit_cnt;

  modport master (
    output i_en, i_valid, i_bit, i_clear,
    input  o_locked, o_err, o_err_cnt, o_bit_cnt
  );

  modport slave (
    input  i_en, i_valid, i_bit, i_clear,
    output o_locked, o_err, o_err_cnt, o_bit_cnt
  );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising checker for the 32-bit Fibonacci PRBS stream (taps 3,8,11,15,18,24,29).
// Fills from the line, verifies predictions, then flywheels while counting bit errors.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | disabled; nothing shifts, waits for i_en
//   FILL    | loading 32 received bits into the predictor
//   VERIFY  | received bits must match prediction LOCK_GOOD times in a row
//   LOCKED  | flywheel prediction, error/bit counting, windowed loss check
module lfsr_prbs_checker #(
  parameter int CNT_W     = 16,
  parameter int LOCK_GOOD = 32,
  parameter int LOSS_ERR  = 8,
  parameter int WINDOW    = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  lfsr_prbs_checker_if.slave  bus
);

  localparam int          WI_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int          WE_W = $clog2(LOSS_ERR + 1);
  localparam logic [31:0] TAPS = 32'h2104_8908;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      s_q;
  logic [4:0]       fill_q;
  logic [7:0]       good_q;
  logic [WI_W-1:0]  win_q;
  logic [WE_W-1:0]  werr_q;
  logic [CNT_W-1:0] err_cnt_q, bit_cnt_q;
  logic             err_q, locked_q;

  logic            pred, mis, loss;
  logic [WE_W-1:0] werr_sum;

  logic clr_all, shift_rx, shift_fly;
  logic load_fill_full, load_fill_rest, dec_fill;
  logic load_good, dec_good;
  logic win_load, win_step;
  logic count_bit, count_err;

  always_comb begin
    pred     = ^(s_q & TAPS);
    mis      = bus.i_valid & (bus.i_bit ^ pred);
    werr_sum = werr_q + WE_W'(mis);
    loss     = (werr_sum >= WE_W'(LOSS_ERR));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Timers are down-counters: fill/good/window terminal count is zero.
  always_comb begin
    state_d        = state_q;
    clr_all        = 1'b0;
    shift_rx       = 1'b0;
    shift_fly      = 1'b0;
    load_fill_full = 1'b0;
    load_fill_rest = 1'b0;
    dec_fill       = 1'b0;
    load_good      = 1'b0;
    dec_good       = 1'b0;
    win_load       = 1'b0;
    win_step       = 1'b0;
    count_bit      = 1'b0;
    count_err      = 1'b0;
    if (!bus.i_en) begin
      state_d = ST_IDLE;
      clr_all = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d        = ST_FILL;
          load_fill_full = 1'b1;
        end
        ST_FILL: begin
          if (bus.i_valid) begin
            shift_rx = 1'b1;
            if (fill_q == '0) begin
              state_d   = ST_VERIFY;
              load_good = 1'b1;
            end else begin
              dec_fill = 1'b1;
            end
          end
        end
        ST_VERIFY: begin
          if (bus.i_valid) begin
            shift_rx = 1'b1;
            if (mis) begin
              // The failing bit is already in the register, so it is fill bit 1.
              state_d        = ST_FILL;
              load_fill_rest = 1'b1;
            end else if (good_q == '0) begin
              state_d  = ST_LOCKED;
              win_load = 1'b1;
            end else begin
              dec_good = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (bus.i_valid) begin
            shift_fly = 1'b1;
            count_bit = 1'b1;
            count_err = mis;
            if (loss) begin
              state_d        = ST_FILL;
              load_fill_full = 1'b1;
              win_load       = 1'b1;
            end else if (win_q == '0) begin
              win_load = 1'b1;
            end else begin
              win_step = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_q       <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      win_q     <= '0;
      werr_q    <= '0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      locked_q <= (state_d == ST_LOCKED);
      err_q    <= count_err;

      if (clr_all)        s_q <= '0;
      else if (shift_rx)  s_q <= {s_q[30:0], bus.i_bit};
      else if (shift_fly) s_q <= {s_q[30:0], pred};

      if (clr_all)             fill_q <= '0;
      else if (load_fill_full) fill_q <= 5'd31;
      else if (load_fill_rest) fill_q <= 5'd30;
      else if (dec_fill)       fill_q <= fill_q - 5'd1;

      if (clr_all)        good_q <= '0;
      else if (load_good) good_q <= 8'(LOCK_GOOD - 1);
      else if (dec_good)  good_q <= good_q - 8'd1;

      if (clr_all) begin
        win_q  <= '0;
        werr_q <= '0;
      end else if (win_load) begin
        win_q  <= WI_W'(WINDOW - 1);
        werr_q <= '0;
      end else if (win_step) begin
        win_q  <= win_q - WI_W'(1);
        werr_q <= werr_sum;
      end

      // Clear takes priority over a same-cycle increment.
      if (bus.i_clear) begin
        err_cnt_q <= '0;
        bit_cnt_q <= '0;
      end else begin
        if (count_bit && (bit_cnt_q != '1)) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        if (count_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.o_locked  = locked_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;
  assign bus.o_bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: two configurations share one directed stream from a generator LFSR;
// a spec-level model is compared every cycle, plus hand-computed checkpoints.
module tb_lfsr_prbs_checker;

  localparam int M_IDLE   = 0;
  localparam int M_FILL   = 1;
  localparam int M_VERIFY = 2;
  localparam int M_LOCKED = 3;

  typedef struct {
    int          mode;
    int          fill;
    int          good;
    int          widx;
    int          werr;
    logic [31:0] h;
    int          errc;
    int          bitc;
    logic        err;
    logic        locked;
  } mst_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en, valid, bit_in, clear;
  logic run_cmp = 1'b0;
  logic [31:0] g;
  mst_t ma, mb;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_prbs_checker_if #(.CNT_W(16)) bus_a ();
  lfsr_prbs_checker_if #(.CNT_W(4))  bus_b ();

  assign bus_a.i_en = en;  assign bus_a.i_valid = valid;
  assign bus_a.i_bit = bit_in;  assign bus_a.i_clear = clear;
  assign bus_b.i_en = en;  assign bus_b.i_valid = valid;
  assign bus_b.i_bit = bit_in;  assign bus_b.i_clear = clear;

  lfsr_prbs_checker #(.CNT_W(16), .LOCK_GOOD(32), .LOSS_ERR(8), .WINDOW(64)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave));
  lfsr_prbs_checker #(.CNT_W(4), .LOCK_GOOD(32), .LOSS_ERR(64), .WINDOW(64)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave));

  function automatic mst_t mzero();
    mst_t z;
    z.mode = M_IDLE; z.fill = 0; z.good = 0; z.widx = 0; z.werr = 0;
    z.h = '0; z.errc = 0; z.bitc = 0; z.err = 1'b0; z.locked = 1'b0;
    return z;
  endfunction

  function automatic mst_t mstep(mst_t m, logic e, logic v, logic b, logic clr,
                                 int lg, int loss, int win, int cmax);
    mst_t n = m;
    logic p, mm;
    p  = m.h[3] ^ m.h[8] ^ m.h[11] ^ m.h[15] ^ m.h[18] ^ m.h[24] ^ m.h[29];
    mm = v & (b ^ p);
    n.err = 1'b0;
    if (!e) begin
      n.mode = M_IDLE; n.h = '0; n.fill = 0; n.good = 0; n.widx = 0; n.werr = 0;
    end else if (m.mode == M_IDLE) begin
      n.mode = M_FILL; n.fill = 0;
    end else if (v) begin
      if (m.mode == M_FILL) begin
        n.h = {m.h[30:0], b};
        n.fill = m.fill + 1;
        if (n.fill == 32) begin n.mode = M_VERIFY; n.good = 0; end
      end else if (m.mode == M_VERIFY) begin
        n.h = {m.h[30:0], b};
        if (mm) begin
          n.mode = M_FILL; n.fill = 1;
        end else begin
          n.good = m.good + 1;
          if (n.good == lg) begin n.mode = M_LOCKED; n.widx = 0; n.werr = 0; end
        end
      end else begin
        n.h = {m.h[30:0], p};
        n.bitc = (m.bitc < cmax) ? m.bitc + 1 : cmax;
        if (mm) begin
          n.err = 1'b1;
          n.errc = (m.errc < cmax) ? m.errc + 1 : cmax;
          n.werr = m.werr + 1;
        end
        if (n.werr >= loss) begin
          n.mode = M_FILL; n.fill = 0; n.werr = 0; n.widx = 0;
        end else if (m.widx == win - 1) begin
          n.widx = 0; n.werr = 0;
        end else begin
          n.widx = m.widx + 1;
        end
      end
    end
    if (clr) begin n.errc = 0; n.bitc = 0; end
    n.locked = (n.mode == M_LOCKED);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = mzero();
      mb = mzero();
    end else begin
      ma = mstep(ma, en, valid, bit_in, clear, 32, 8, 64, 65535);
      mb = mstep(mb, en, valid, bit_in, clear, 32, 64, 64, 15);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("a_locked",  32'(bus_a.o_locked),  32'(ma.locked));
      chk("a_err",     32'(bus_a.o_err),     32'(ma.err));
      chk("a_err_cnt", 32'(bus_a.o_err_cnt), 32'(ma.errc));
      chk("a_bit_cnt", 32'(bus_a.o_bit_cnt), 32'(ma.bitc));
      chk("b_locked",  32'(bus_b.o_locked),  32'(mb.locked));
      chk("b_err",     32'(bus_b.o_err),     32'(mb.err));
      chk("b_err_cnt", 32'(bus_b.o_err_cnt), 32'(mb.errc));
      chk("b_bit_cnt", 32'(bus_b.o_bit_cnt), 32'(mb.bitc));
    end
  end

  function automatic logic gen_next();
    logic fb;
    fb = g[3] ^ g[8] ^ g[11] ^ g[15] ^ g[18] ^ g[24] ^ g[29];
    g  = {g[30:0], fb};
    return fb;
  endfunction

  // Applies one cycle of input at posedge+1 and returns at the next posedge+1.
  task automatic step(input logic v, input logic flip);
    valid  = v;
    bit_in = v ? (gen_next() ^ flip) : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 1'b0);
    clear = 1'b0;
  endtask

  initial begin
    ma = mzero();
    mb = mzero();
    en = 1'b0; valid = 1'b0; bit_in = 1'b0; clear = 1'b0; rst_n = 1'b0;
    g = 32'h5CA7_7A5C;
    repeat (3) @(posedge clk);
    #1;
    run_cmp = 1'b1;
    chk("rst_a_locked",  32'(bus_a.o_locked),  32'd0);
    chk("rst_a_err_cnt", 32'(bus_a.o_err_cnt), 32'd0);
    chk("rst_b_bit_cnt", 32'(bus_b.o_bit_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Acquisition: 32 fill + 32 verify bits
    en = 1'b1;
    step(1'b0, 1'b0);
    run(63);
    chk("acq_not_yet", 32'(bus_a.o_locked), 32'd0);
    step(1'b1, 1'b0);
    chk("acq_locked_a", 32'(bus_a.o_locked), 32'd1);
    chk("acq_locked_b", 32'(bus_b.o_locked), 32'd1);
    run(100);
    chk("clean_bit_cnt", 32'(bus_a.o_bit_cnt), 32'd100);
    chk("clean_err_cnt", 32'(bus_a.o_err_cnt), 32'd0);

    // Single error
    step(1'b1, 1'b1);
    chk("single_err_pulse", 32'(bus_a.o_err), 32'd1);
    chk("single_err_cnt",   32'(bus_a.o_err_cnt), 32'd1);
    step(1'b1, 1'b0);
    chk("single_err_end", 32'(bus_a.o_err), 32'd0);
    run(70);
    chk("single_err_hold", 32'(bus_a.o_err_cnt), 32'd1);
    chk("single_err_lock", 32'(bus_a.o_locked), 32'd1);

    // Eight errors in one window drop lock, then relock after 64 bits
    do_clear();
    chk("clear_err_cnt", 32'(bus_a.o_err_cnt), 32'd0);
    repeat (7) step(1'b1, 1'b1);
    chk("loss_7_held", 32'(bus_a.o_locked), 32'd1);
    step(1'b1, 1'b1);
    chk("loss_8_drop", 32'(bus_a.o_locked), 32'd0);
    chk("loss_8_cnt",  32'(bus_a.o_err_cnt), 32'd8);
    run(63);
    chk("relock_not_yet", 32'(bus_a.o_locked), 32'd0);
    step(1'b1, 1'b0);
    chk("relock", 32'(bus_a.o_locked), 32'd1);

    // Errors straddling a window boundary: 7 at k=57..63, 1 at k=0
    do_clear();
    run(57);
    repeat (7) step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("straddle_lock", 32'(bus_a.o_locked), 32'd1);
    chk("straddle_cnt",  32'(bus_a.o_err_cnt), 32'd8);
    run(5);
    chk("straddle_lock2", 32'(bus_a.o_locked), 32'd1);

    // Error during VERIFY at good=20 restarts FILL and is not counted
    en = 1'b0;
    step(1'b0, 1'b0);
    en = 1'b1;
    step(1'b0, 1'b0);
    run(52);
    step(1'b1, 1'b1);
    run(62);
    chk("verify_err_nolock", 32'(bus_a.o_locked), 32'd0);
    chk("verify_err_nocnt",  32'(bus_a.o_err_cnt), 32'd8);
    run(2);
    chk("verify_err_relock", 32'(bus_a.o_locked), 32'd1);

    // Saturation on the 4-bit instance, then clear beating an increment
    do_clear();
    repeat (20) step(1'b1, 1'b1);
    chk("sat_err_cnt", 32'(bus_b.o_err_cnt), 32'd15);
    chk("sat_err_pls", 32'(bus_b.o_err), 32'd1);
    chk("sat_lock",    32'(bus_b.o_locked), 32'd1);
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    chk("clr_wins_err", 32'(bus_b.o_err_cnt), 32'd0);
    chk("clr_wins_bit", 32'(bus_b.o_bit_cnt), 32'd0);
    chk("clr_err_pls",  32'(bus_b.o_err), 32'd1);

    // 50% valid: lock still needs 64 valid bits
    en = 1'b0;
    step(1'b0, 1'b0);
    en = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 63; i++) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    chk("half_not_yet", 32'(bus_a.o_locked), 32'd0);
    step(1'b1, 1'b0);
    chk("half_lock_a", 32'(bus_a.o_locked), 32'd1);
    chk("half_lock_b", 32'(bus_b.o_locked), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end

    // Asynchronous reset mid-lock
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a_locked",  32'(bus_a.o_locked),  32'd0);
    chk("arst_a_bit_cnt", 32'(bus_a.o_bit_cnt), 32'd0);
    chk("arst_b_locked",  32'(bus_b.o_locked),  32'd0);
    chk("arst_b_bit_cnt", 32'(bus_b.o_bit_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    run(63);
    chk("arst_relock_not_yet", 32'(bus_a.o_locked), 32'd0);
    step(1'b1, 1'b0);
    chk("arst_relock", 32'(bus_a.o_locked), 32'd1);
    run(4);

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
